// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared CPU types for fetch/decode: register number, NOP word, hazard FSM states
package hazard_ctrl_pkg;
   localparam int REG_W = 3;
   localparam logic [15:0] NOP = 16'h0000;
   typedef logic [REG_W-1:0] reg_t;
   typedef enum logic [1:0] {RUN, MISS_REQ, MISS_WAIT, RESUME} state_e;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline/I-cache side of the hazard controller
//   master (pipeline, I-cache): drives hit, refill_done, pcSrc, ID/EX register info
//   slave  (hazard_ctrl): drives PC/IF/ID/ID/EX enables and flushes, refill_req, event counters
interface hazard_ctrl_if
   import hazard_ctrl_pkg::*;
#(parameter int CNT_W = 16);
   logic hit;
   logic refill_done;
   logic pcSrc;
   reg_t id_rs;
   reg_t id_rt;
   logic id_uses_rs;
   logic id_uses_rt;
   logic ex_memRead;
   reg_t ex_rt;
   logic pc_write;
   logic ifid_write;
   logic ifid_flush;
   logic idex_flush;
   logic refill_req;
   logic [CNT_W-1:0] miss_cnt;
   logic [CNT_W-1:0] stall_cnt;
   modport master (
      output hit, refill_done, pcSrc, id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memRead, ex_rt,
      input  pc_write, ifid_write, ifid_flush, idex_flush, refill_req, miss_cnt, stall_cnt
   );
   modport slave (
      input  hit, refill_done, pcSrc, id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memRead, ex_rt,
      output pc_write, ifid_write, ifid_flush, idex_flush, refill_req, miss_cnt, stall_cnt
   );
endinterface

// File: rtl/hazard_lu_detect.sv
// hazard_lu_detect: combinational load-use hazard compare between the EX load and the ID sources
//   in : ex_memRead_i, ex_rt_i, id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i
//   out: load_use_o
module hazard_lu_detect
   import hazard_ctrl_pkg::*;
(
   input  logic ex_memRead_i,
   input  reg_t ex_rt_i,
   input  reg_t id_rs_i,
   input  reg_t id_rt_i,
   input  logic id_uses_rs_i,
   input  logic id_uses_rt_i,
   output logic load_use_o
);
   // register 0 is hardwired zero, so a load targeting it never creates a dependency
   assign load_use_o = ex_memRead_i && ex_rt_i != '0 &&
                       ((id_uses_rs_i && id_rs_i == ex_rt_i) || (id_uses_rt_i && id_rt_i == ex_rt_i));
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: I-cache miss FSM, load-use stall and branch flush control with event counters
//   in : clk, rst_n (async, active low), hz.slave inputs (hit, refill_done, pcSrc, ID/EX regs)
//   out: hz.slave outputs (pc_write, ifid_write, ifid_flush, idex_flush, refill_req,
//        miss_cnt, stall_cnt), state_o (current FSM state for observation)
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int CNT_W      = 16,
   parameter int MAX_REFILL = 64
)
(
   input  logic         clk,
   input  logic         rst_n,
   hazard_ctrl_if.slave hz,
   output state_e       state_o
);
   localparam int TW = $clog2(MAX_REFILL + 1);
   state_e           state_q, state_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d, stall_cnt_q, stall_cnt_d;
   logic             load_use, fetch_ok, timeout, pc_write;

   hazard_lu_detect u_lu (
      .ex_memRead_i (hz.ex_memRead),
      .ex_rt_i      (hz.ex_rt),
      .id_rs_i      (hz.id_rs),
      .id_rt_i      (hz.id_rt),
      .id_uses_rs_i (hz.id_uses_rs),
      .id_uses_rt_i (hz.id_uses_rt),
      .load_use_o   (load_use)
   );

   assign fetch_ok = state_q == RUN && hz.hit;
   assign timeout  = timer_q == TW'(MAX_REFILL - 1);

   // pcSrc overrides everything; load-use holds PC and IF/ID; a failed fetch feeds a NOP into IF/ID
   assign pc_write      = hz.pcSrc || (!load_use && fetch_ok);
   assign hz.pc_write   = pc_write;
   assign hz.ifid_write = hz.pcSrc || !load_use;
   assign hz.ifid_flush = hz.pcSrc || (!load_use && !fetch_ok);
   assign hz.idex_flush = hz.pcSrc || load_use;
   assign hz.refill_req = state_q == MISS_REQ;
   assign hz.miss_cnt   = miss_cnt_q;
   assign hz.stall_cnt  = stall_cnt_q;
   assign state_o       = state_q;

   // pcSrc is deliberately ignored here: a started miss always completes through RESUME
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      case (state_q)
         RUN:       state_d = hz.hit ? RUN : MISS_REQ;
         MISS_REQ:  begin
            state_d = MISS_WAIT;
            timer_d = '0;
         end
         MISS_WAIT: begin
            state_d = hz.refill_done ? RESUME : timeout ? MISS_REQ : MISS_WAIT;
            timer_d = timer_q + 1'b1;
         end
         default:   state_d = RUN;
      endcase
   end

   // only the RUN->MISS_REQ edge is a new miss; timeout reissues leave miss_cnt alone
   always_comb begin
      miss_cnt_d  = (state_q == RUN && !hz.hit && miss_cnt_q != '1) ? miss_cnt_q + 1'b1 : miss_cnt_q;
      stall_cnt_d = (!pc_write && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         timer_q     <= '0;
         miss_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         miss_cnt_q  <= miss_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: self-checking bench for hazard_ctrl, default build and a small-counter/short-timeout build
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hazard_ctrl_if #(.CNT_W(16)) ia ();
   hazard_ctrl_if #(.CNT_W(3))  ib ();
   state_e st_a, st_b;

   hazard_ctrl #(.CNT_W(16), .MAX_REFILL(64)) dut_a (.clk(clk), .rst_n(rst_n), .hz(ia.slave), .state_o(st_a));
   hazard_ctrl #(.CNT_W(3),  .MAX_REFILL(4))  dut_b (.clk(clk), .rst_n(rst_n), .hz(ib.slave), .state_o(st_b));

   assign ib.hit         = ia.hit;
   assign ib.refill_done = ia.refill_done;
   assign ib.pcSrc       = ia.pcSrc;
   assign ib.id_rs       = ia.id_rs;
   assign ib.id_rt       = ia.id_rt;
   assign ib.id_uses_rs  = ia.id_uses_rs;
   assign ib.id_uses_rt  = ia.id_uses_rt;
   assign ib.ex_memRead  = ia.ex_memRead;
   assign ib.ex_rt       = ia.ex_rt;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] ctl_a();
      return {ia.pc_write, ia.ifid_write, ia.ifid_flush, ia.idex_flush};
   endfunction

   function automatic logic [3:0] ctl_b();
      return {ib.pc_write, ib.ifid_write, ib.ifid_flush, ib.idex_flush};
   endfunction

   // expected {pc_write, ifid_write, ifid_flush, idex_flush} straight from the priority list
   function automatic logic [3:0] ref_ctl(input bit run, hit, pcsrc, mr, input int ert, irs, irt, input bit urs, urt);
      bit lu;
      lu = mr && ert != 0 && ((urs && irs == ert) || (urt && irt == ert));
      if (pcsrc) return 4'b1111;
      if (lu) return 4'b0001;
      if (!(run && hit)) return 4'b0110;
      return 4'b1100;
   endfunction

   task automatic idle();
      ia.hit = 1'b1; ia.refill_done = 1'b0; ia.pcSrc = 1'b0;
      ia.id_rs = '0; ia.id_rt = '0; ia.id_uses_rs = 1'b0; ia.id_uses_rt = 1'b0;
      ia.ex_memRead = 1'b0; ia.ex_rt = '0;
   endtask

   task automatic cyc(input bit h, input bit rd, input bit ps);
      ia.hit = h; ia.refill_done = rd; ia.pcSrc = ps;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      bit hit, pcsrc, mr;
      int ert, irs, irt;
      bit urs, urt;
      logic [3:0] exp;
   } vec_t;
   vec_t tbl[11];

   // high-level miss model: a miss is "age" cycles old; every (MAX_REFILL+1) cycles a request is (re)issued
   int     mr_p[2]  = '{64, 4};
   longint cmax[2]  = '{65535, 7};
   bit     in_miss[2], resume[2];
   int     age[2];
   longint m_miss[2], m_stall[2];

   function automatic state_e model_state(input int d);
      if (resume[d]) return RESUME;
      if (in_miss[d]) return (age[d] % (mr_p[d] + 1) == 0) ? MISS_REQ : MISS_WAIT;
      return RUN;
   endfunction

   task automatic model_step(input int d, input logic [3:0] ctl);
      state_e s;
      s = model_state(d);
      if (!ctl[3]) m_stall[d] = (m_stall[d] + 1 > cmax[d]) ? cmax[d] : m_stall[d] + 1;
      if (resume[d]) resume[d] = 1'b0;
      else if (in_miss[d]) begin
         if (s == MISS_WAIT && ia.refill_done) begin
            in_miss[d] = 1'b0;
            resume[d] = 1'b1;
         end else age[d]++;
      end else if (!ia.hit) begin
         in_miss[d] = 1'b1;
         age[d] = 0;
         m_miss[d] = (m_miss[d] + 1 > cmax[d]) ? cmax[d] : m_miss[d] + 1;
      end
   endtask

   task automatic check_dut(input int d, input state_e st, input logic [3:0] ctl, input logic rr, input longint mc, input longint sc);
      state_e   es;
      logic [3:0] ec;
      es = model_state(d);
      ec = ref_ctl(es == RUN, ia.hit, ia.pcSrc, ia.ex_memRead, int'(ia.ex_rt), int'(ia.id_rs), int'(ia.id_rt),
                   ia.id_uses_rs, ia.id_uses_rt);
      chk($sformatf("rnd%0d.state", d), st, es);
      chk($sformatf("rnd%0d.ctl", d), ctl, ec);
      chk($sformatf("rnd%0d.refill_req", d), rr, es == MISS_REQ);
      chk($sformatf("rnd%0d.miss_cnt", d), mc, m_miss[d]);
      chk($sformatf("rnd%0d.stall_cnt", d), sc, m_stall[d]);
      model_step(d, ec);
   endtask

   initial begin
      state_e exp_seq[9];
      int pw0;
      idle();
      #1;
      chk("rst.state", st_a, RUN);
      chk("rst.ctl_hit", ctl_a(), 4'b1100);
      chk("rst.miss_cnt", ia.miss_cnt, 0);
      chk("rst.stall_cnt", ia.stall_cnt, 0);
      ia.hit = 1'b0;
      @(posedge clk);
      #1;
      chk("rst.ctl_miss", ctl_a(), 4'b0110);
      chk("rst.refill_req", ia.refill_req, 0);
      chk("rst.state_b", st_b, RUN);
      rst_n = 1'b1;
      idle();

      tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 4'b1100};
      tbl[1]  = '{1, 0, 1, 3, 3, 0, 1, 0, 4'b0001};
      tbl[2]  = '{1, 0, 1, 3, 0, 3, 0, 1, 4'b0001};
      tbl[3]  = '{1, 0, 1, 3, 3, 0, 0, 0, 4'b1100};
      tbl[4]  = '{1, 0, 1, 0, 0, 0, 1, 1, 4'b1100};
      tbl[5]  = '{1, 1, 1, 3, 3, 0, 1, 0, 4'b1111};
      tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 4'b0110};
      tbl[7]  = '{0, 0, 1, 2, 2, 0, 1, 0, 4'b0001};
      tbl[8]  = '{1, 0, 0, 3, 3, 0, 1, 0, 4'b1100};
      tbl[9]  = '{0, 1, 0, 0, 0, 0, 0, 0, 4'b1111};
      tbl[10] = '{1, 0, 1, 5, 2, 5, 1, 1, 4'b0001};
      do_reset();
      for (int i = 0; i < 11; i++) begin
         ia.hit = tbl[i].hit; ia.pcSrc = tbl[i].pcsrc; ia.ex_memRead = tbl[i].mr;
         ia.ex_rt = reg_t'(tbl[i].ert); ia.id_rs = reg_t'(tbl[i].irs); ia.id_rt = reg_t'(tbl[i].irt);
         ia.id_uses_rs = tbl[i].urs; ia.id_uses_rt = tbl[i].urt;
         #1;
         chk($sformatf("tbl%0d.ctl_a", i), ctl_a(), tbl[i].exp);
         chk($sformatf("tbl%0d.ctl_b", i), ctl_b(), tbl[i].exp);
         chk($sformatf("tbl%0d.refill_req", i), ia.refill_req, 0);
         idle();
         @(negedge clk);
      end

      do_reset();
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("steady.ctl", ctl_a(), 4'b1100);
         @(negedge clk);
      end
      #1;
      chk("steady.stall_cnt", ia.stall_cnt, 0);

      ia.ex_memRead = 1'b1; ia.ex_rt = 3'd3; ia.id_rs = 3'd3; ia.id_uses_rs = 1'b1;
      #1;
      chk("lu.ctl", ctl_a(), 4'b0001);
      @(negedge clk);
      idle();
      #1;
      chk("lu.after_ctl", ctl_a(), 4'b1100);
      chk("lu.stall_cnt", ia.stall_cnt, 1);
      ia.ex_memRead = 1'b1; ia.ex_rt = 3'd0; ia.id_rs = 3'd0; ia.id_uses_rs = 1'b1;
      #1;
      chk("lu_r0.ctl", ctl_a(), 4'b1100);
      @(negedge clk);
      idle();
      #1;
      chk("lu_r0.stall_cnt", ia.stall_cnt, 1);

      exp_seq = '{RUN, MISS_REQ, MISS_WAIT, MISS_WAIT, MISS_WAIT, MISS_WAIT, MISS_WAIT, RESUME, RUN};
      do_reset();
      pw0 = 0;
      for (int k = 0; k < 9; k++) begin
         cyc(k != 0, k == 6, 1'b0);
         chk($sformatf("miss.state%0d", k), st_a, exp_seq[k]);
         chk($sformatf("miss.refill_req%0d", k), ia.refill_req, k == 1);
         if (!ia.pc_write) pw0++;
         @(negedge clk);
      end
      chk("miss.pw0_cycles", pw0, 8);
      chk("miss.miss_cnt", ia.miss_cnt, 1);
      chk("miss.stall_cnt", ia.stall_cnt, 8);

      do_reset();
      for (int k = 0; k < 21; k++) begin
         cyc(k != 0, 1'b0, 1'b0);
         chk($sformatf("reissue.refill_req%0d", k), ib.refill_req, k >= 1 && (k - 1) % 5 == 0);
         @(negedge clk);
      end
      #1;
      chk("reissue.miss_cnt", ib.miss_cnt, 1);

      do_reset();
      cyc(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      cyc(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      cyc(1'b1, 1'b0, 1'b1);
      chk("br_wait.state", st_a, MISS_WAIT);
      chk("br_wait.ctl", ctl_a(), 4'b1111);
      @(negedge clk);
      cyc(1'b1, 1'b1, 1'b0);
      chk("br_wait.state2", st_a, MISS_WAIT);
      @(negedge clk);
      cyc(1'b1, 1'b0, 1'b0);
      chk("br_wait.resume", st_a, RESUME);
      @(negedge clk);
      cyc(1'b1, 1'b0, 1'b0);
      chk("br_wait.run", st_a, RUN);
      chk("br_wait.miss_cnt", ia.miss_cnt, 1);

      do_reset();
      cyc(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      cyc(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      cyc(1'b1, 1'b0, 1'b0);
      chk("arst.pre_state", st_a, MISS_WAIT);
      chk("arst.pre_stall", ia.stall_cnt, 2);
      rst_n = 1'b0;
      #1;
      chk("arst.state", st_a, RUN);
      chk("arst.miss_cnt", ia.miss_cnt, 0);
      chk("arst.stall_cnt", ia.stall_cnt, 0);
      chk("arst.refill_req", ia.refill_req, 0);
      chk("arst.ctl", ctl_a(), 4'b1100);
      @(negedge clk);
      rst_n = 1'b1;

      do_reset();
      for (int i = 0; i < 40; i++) begin
         cyc(1'b0, 1'b1, 1'b0);
         @(negedge clk);
      end
      #1;
      chk("sat.miss_a", ia.miss_cnt, 10);
      chk("sat.stall_a", ia.stall_cnt, 40);
      chk("sat.miss_b", ib.miss_cnt, 7);
      chk("sat.stall_b", ib.stall_cnt, 7);

      do_reset();
      for (int d = 0; d < 2; d++) begin
         in_miss[d] = 1'b0; resume[d] = 1'b0; age[d] = 0; m_miss[d] = 0; m_stall[d] = 0;
      end
      for (int n = 0; n < 600; n++) begin
         ia.hit = $urandom_range(0, 9) != 0;
         ia.refill_done = $urandom_range(0, 5) == 0;
         ia.pcSrc = $urandom_range(0, 7) == 0;
         ia.ex_memRead = $urandom_range(0, 2) == 0;
         ia.ex_rt = reg_t'($urandom_range(0, 3));
         ia.id_rs = reg_t'($urandom_range(0, 3));
         ia.id_rt = reg_t'($urandom_range(0, 3));
         ia.id_uses_rs = 1'($urandom_range(0, 1));
         ia.id_uses_rt = 1'($urandom_range(0, 1));
         #1;
         check_dut(0, st_a, ctl_a(), ia.refill_req, ia.miss_cnt, ia.stall_cnt);
         check_dut(1, st_b, ctl_b(), ib.refill_req, ib.miss_cnt, ib.stall_cnt);
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, sets the width of the event counters.
REQ-002 Parameter MAX_REFILL, default 64, sets the number of MISS_WAIT cycles before refill_req is reissued.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 hit  in  1  I-cache hit for the current fetch PC.
REQ-006 refill_done  in  1  one-cycle pulse: the missed line has been written into the I-cache.
REQ-007 pcSrc  in  1  taken branch resolved; PC redirect to branch_target.
REQ-008 id_rs, id_rt  in  3 each  source register numbers of the instruction in ID.
REQ-009 id_uses_rs, id_uses_rt  in  1 each  the ID instruction reads rs / rt.
REQ-010 ex_memRead  in  1  the instruction in EX is a load.
REQ-011 ex_rt  in  3  destination register number of that load.
REQ-012 pc_write  out  1  PC register load enable.
REQ-013 ifid_write  out  1  IF/ID register load enable.
REQ-014 ifid_flush  out  1  IF/ID loads a NOP (16'h0000) instead of the fetched instruction.
REQ-015 idex_flush  out  1  ID/EX loads a bubble (all control bits zero).
REQ-016 refill_req  out  1  one-cycle request to fetch the missed line.
REQ-017 miss_cnt, stall_cnt  out  CNT_W each  saturating counters of I-cache misses and PC-hold cycles.

Function
REQ-018 The FSM SHALL have four states: RUN, MISS_REQ, MISS_WAIT and RESUME.
REQ-019 Transitions SHALL be:
- RUN -> MISS_REQ when hit=0
- MISS_REQ -> MISS_WAIT unconditionally
- MISS_WAIT -> RESUME on refill_done
- MISS_WAIT -> MISS_REQ when the wait timer reaches MAX_REFILL-1 without refill_done
- RESUME -> RUN unconditionally
REQ-020 refill_req SHALL be 1 only in MISS_REQ.
REQ-021 The wait timer SHALL clear on entry to MISS_WAIT and increment on every MISS_WAIT cycle.
REQ-022 refill_done SHALL be ignored outside MISS_WAIT.
REQ-023 load_use SHALL be ex_memRead & ex_rt!=0 & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
REQ-024 fetch_ok SHALL be (state==RUN) & hit.
REQ-025 All outputs other than the counters SHALL be combinational from state and inputs, with this priority:
- pcSrc=1: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1; load_use is ignored.
- else load_use=1: pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=1.
- else fetch_ok=0: pc_write=0, ifid_write=1, ifid_flush=1, idex_flush=0.
- else: pc_write=1, ifid_write=1, ifid_flush=0, idex_flush=0.
REQ-026 pcSrc during MISS_REQ or MISS_WAIT SHALL NOT abort the miss; the FSM completes the refill and passes through RESUME, and hit is re-evaluated in RUN at the redirected PC.
REQ-027 miss_cnt SHALL increment on each RUN->MISS_REQ transition; timeout reissues SHALL NOT count.
REQ-028 stall_cnt SHALL increment on every cycle with pc_write=0.
REQ-029 Both counters SHALL saturate at 2^CNT_W-1.
REQ-030 Load-use hold and a miss in the same cycle SHALL both apply: ID is held by REQ-025, and the FSM still enters MISS_REQ.
REQ-031 A load-use stall SHALL last exactly one cycle per hazard, since the bubble clears ex_memRead.

Reset
REQ-032 rst_n=0 SHALL asynchronously force state=RUN, wait timer=0, miss_cnt=0 and stall_cnt=0, including mid-miss.
REQ-033 During reset, refill_req SHALL be 0 and the other outputs SHALL follow REQ-025 with state=RUN.
REQ-034 After rst_n deasserts, the first rising edge SHALL be a normal RUN cycle.

Structure
REQ-035 The state encoding, NOP value 16'h0000 and register-number width 3 SHALL live in the shared CPU package used by the fetch and decode stages.
REQ-036 One sub-module, hazard_lu_detect, SHALL hold the combinational load-use compare of REQ-023.
REQ-037 The FSM, wait timer and counters SHALL reside in hazard_ctrl.

Verification
REQ-038 Steady hit=1 with no hazards for 10 cycles -> pc_write=1 and all flushes 0 throughout; stall_cnt=0.
REQ-039 ex_memRead=1, ex_rt=3, id_rs=3, id_uses_rs=1 -> for one cycle pc_write=0, ifid_write=0, idex_flush=1; stall_cnt=1.
REQ-040 The same hazard with ex_rt=0 -> no stall.
REQ-041 hit=0 in RUN, refill_done 5 cycles after refill_req -> state sequence RUN, MISS_REQ, MISS_WAIT x5, RESUME, RUN; miss_cnt=1; pc_write=0 for 8 cycles.
REQ-042 With MAX_REFILL=4 and no refill_done -> refill_req pulses every 5 cycles while miss_cnt stays 1.
REQ-043 pcSrc=1 in MISS_WAIT -> pc_write=1, ifid_flush=1, idex_flush=1 that cycle, and the miss still completes.
REQ-044 rst_n=0 mid-MISS_WAIT -> state RUN, counters 0 and refill_req=0 immediately, without waiting for a clock edge.
